prbs17_checker: RTL

- Receive-side counterpart to the team's 17-bit LFSR generator.
- Consumes the generator's parallel 17-bit state word, one word per valid cycle.
- Self-synchronises to the sequence, declares lock, then flywheels its own prediction.
- Counts and flags mismatches; used in benches and on-chip BIST to prove the link or sequence is intact.

---
 rtl/prbs17_checker.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/prbs17_checker.sv
// Receive-side checker for the 17-bit Fibonacci LFSR (taps 14, 17) state word stream.
// Latency: all outputs registered, one clock after the sampling edge.
// Backpressure: none; words are consumed whenever in_valid is high, idle cycles freeze state.
module prbs17_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:17]      in_word,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_flag,
  output logic             zero_flag,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count
);

  // match_cnt only ever holds 0..LOCK_COUNT-1, miss_cnt only 0..LOSS_COUNT-1
  localparam int MW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam int LW = (LOSS_COUNT > 1) ? $clog2(LOSS_COUNT) : 1;
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [LW-1:0] MISS_LAST  = LW'(LOSS_COUNT - 1);

  typedef enum logic [1:0] {
    SEED = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } state_t;

  state_t        state;
  logic [1:17]   pred;
  logic [MW-1:0] match_cnt;
  logic [LW-1:0] miss_cnt;

  logic is_zero;
  logic hit;
  logic cnt_word;
  logic cnt_err;

  // Generator next-state: new MSB is s14 ^ s17, everything else shifts toward the LSB
  function automatic logic [1:17] nxt(input logic [1:17] s);
    return {s[14] ^ s[17], s[1:16]};
  endfunction

  // Saturating counter update; a clear in the same cycle as an event leaves 1
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c,
                                            input logic clr, input logic ev);
    logic [CNT_W-1:0] base;
    base = clr ? '0 : c;
    if (ev && !(&base)) return base + CNT_W'(1);
    return base;
  endfunction

  // Per-word classification and the events the counters see
  always_comb begin
    is_zero  = (in_word == 17'd0);
    hit      = (in_word == pred);
    cnt_word = in_valid && (state == LOCK);
    cnt_err  = cnt_word && !hit;
  end

  // Sync FSM: seed from input, confirm LOCK_COUNT predictions, then flywheel until LOSS_COUNT misses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEED;
      pred      <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_flag  <= 1'b0;
      zero_flag <= 1'b0;
    end else begin
      err_flag  <= 1'b0;
      zero_flag <= 1'b0;
      if (in_valid) begin
        case (state)
          SEED: begin
            if (is_zero) begin
              zero_flag <= 1'b1;
            end else begin
              pred      <= nxt(in_word);
              match_cnt <= '0;
              state     <= SYNC;
            end
          end
          SYNC: begin
            if (is_zero) begin
              zero_flag <= 1'b1;
              state     <= SEED;
            end else if (hit) begin
              pred <= nxt(pred);
              if (match_cnt == MATCH_LAST) begin
                match_cnt <= '0;
                miss_cnt  <= '0;
                locked    <= 1'b1;
                state     <= LOCK;
              end else begin
                match_cnt <= match_cnt + MW'(1);
              end
            end else begin
              // Wrong but legal word: assume we seeded on a corrupted word and retry from this one
              pred      <= nxt(in_word);
              match_cnt <= '0;
            end
          end
          LOCK: begin
            // Flywheel: the input never reseeds the prediction while locked
            pred <= nxt(pred);
            if (hit) begin
              miss_cnt <= '0;
            end else begin
              err_flag  <= 1'b1;
              zero_flag <= is_zero;
              if (miss_cnt == MISS_LAST) begin
                miss_cnt <= '0;
                locked   <= 1'b0;
                state    <= SEED;
              end else begin
                miss_cnt <= miss_cnt + LW'(1);
              end
            end
          end
          default: begin
            state  <= SEED;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  // Statistics counters survive loss of lock; only rst or clr_cnt clears them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count  <= '0;
      word_count <= '0;
    end else begin
      err_count  <= bump(err_count, clr_cnt, cnt_err);
      word_count <= bump(word_count, clr_cnt, cnt_word);
    end
  end

endmodule
